// File: rtl/uart_rx_os.sv
// uart_rx_os: 8N1 UART receiver sampling the line on a 16x oversample tick.
// One-byte holding register with empty, frame-error and overrun status.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for a tick that sees the line low
// S_START | counting to mid start bit to confirm a real start
// S_DATA  | sampling 8 data bits LSB first, one per 16 ticks
// S_STOP  | sampling the stop bit; good stop loads the holding register
// S_BREAK | stop bit was 0; waiting for the line to return high
module uart_rx_os #(
   parameter int unsigned OS_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   input  logic       uld_rx_data,
   output logic [7:0] rx_data,
   output logic       rx_empty,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned PW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(OS_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic          rx_s1_q, rx_s2_q;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick;
   logic          line;

   state_t        state_q, state_d;
   logic [3:0]    scnt_q, scnt_d;
   logic [2:0]    bcnt_q, bcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          load_good, load_bad;

   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_empty_q, rx_empty_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_in;
         rx_s2_q <= rx_s1_q;
      end
   end

   assign line = rx_s2_q;

   // Free-running prescaler: tick is high for one clk out of every OS_DIV.
   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   // Receive FSM and holding-register status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q       <= '0;
         state_q     <= S_IDLE;
         scnt_q      <= 4'd0;
         bcnt_q      <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_empty_q  <= 1'b1;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_empty_q  <= rx_empty_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state logic; every decision is taken only on an oversample tick.
   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      bcnt_d    = bcnt_q;
      shift_d   = shift_q;
      load_good = 1'b0;
      load_bad  = 1'b0;
      if (tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!line) begin
                  state_d = S_START;
                  scnt_d  = 4'd0;
               end
            end
            S_START: begin
               if (scnt_q == 4'd7) begin
                  scnt_d = 4'd0;
                  if (!line) begin
                     state_d = S_DATA;
                     bcnt_d  = 3'd0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            S_DATA: begin
               if (scnt_q == 4'd15) begin
                  shift_d[bcnt_q] = line;
                  scnt_d          = 4'd0;
                  bcnt_d          = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            S_STOP: begin
               if (scnt_q == 4'd15) begin
                  scnt_d = 4'd0;
                  if (line) begin
                     load_good = 1'b1;
                     state_d   = S_IDLE;
                  end else begin
                     load_bad = 1'b1;
                     state_d  = S_BREAK;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            S_BREAK: begin
               if (line) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Holding register: a good-frame load takes priority over an unload strobe
   // in the same cycle, and then the byte is not counted as an overrun.
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_empty_d  = rx_empty_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      if (load_good) begin
         rx_data_d   = shift_q;
         rx_empty_d  = 1'b0;
         frame_err_d = 1'b0;
         overrun_d   = uld_rx_data ? 1'b0 : (overrun_q | ~rx_empty_q);
      end else begin
         if (load_bad) begin
            frame_err_d = 1'b1;
         end
         if (uld_rx_data) begin
            rx_empty_d = 1'b1;
            overrun_d  = 1'b0;
         end
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_empty  = rx_empty_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os at OS_DIV=4 (64 clk per bit). Frames are launched on a
// fixed phase of the prescaler so the stop-sample edge is known exactly.
module tb_uart_rx_os;

   localparam int OS  = 4;
   localparam int BIT = 16 * OS;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_in = 1'b1;
   logic       uld_rx_data = 1'b0;
   logic [7:0] rx_data;
   logic       rx_empty, frame_err, overrun, busy;

   uart_rx_os #(.OS_DIV(OS)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_in       (rx_in),
      .uld_rx_data (uld_rx_data),
      .rx_data     (rx_data),
      .rx_empty    (rx_empty),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; prescaler ticks on edges where cyc%4==0.
   int cyc = 0;
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] exp_q[$];

   function automatic logic [10:0] tup(input logic [7:0] d, input logic e,
                                       input logic f, input logic o);
      return {d, e, f, o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every change of the status tuple is matched against the queue.
   logic        mon_en = 1'b0;
   logic        mon_armed = 1'b0;
   logic [10:0] prev_t, cur_t, exp_t;
   always @(negedge clk) begin
      if (mon_en) begin
         cur_t = {rx_data, rx_empty, frame_err, overrun};
         if (!mon_armed) begin
            prev_t    = cur_t;
            mon_armed = 1'b1;
         end else if (cur_t !== prev_t) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change actual data=%h empty=%b fe=%b ov=%b required no change",
                        cur_t[10:3], cur_t[2], cur_t[1], cur_t[0]);
            end else begin
               exp_t = exp_q.pop_front();
               if (cur_t !== exp_t) begin
                  n_fail++;
                  $display("FAIL scoreboard actual data=%h empty=%b fe=%b ov=%b required data=%h empty=%b fe=%b ov=%b",
                           cur_t[10:3], cur_t[2], cur_t[1], cur_t[0],
                           exp_t[10:3], exp_t[2], exp_t[1], exp_t[0]);
               end
            end
            prev_t = cur_t;
         end
      end
   end

   task automatic align();
      do begin
         @(posedge clk);
         #1;
      end while (cyc % 4 != 1);
   endtask

   // Start bit is driven right after an edge with cyc%4==1, so detection lands
   // 3 edges later and the stop bit is sampled 611 edges after that edge.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic uld_stop);
      align();
      rx_in = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx_in = d[i];
         repeat (BIT) @(posedge clk);
      end
      #1;
      check("busy_in_frame", 32'(busy), 32'd1);
      if (stop_bit) begin
         rx_in = 1'b1;
         if (uld_stop) begin
            repeat (34) @(posedge clk);
            #1 uld_rx_data = 1'b1;
            @(posedge clk);
            #1 uld_rx_data = 1'b0;
            repeat (29) @(posedge clk);
         end else begin
            repeat (BIT) @(posedge clk);
         end
      end else begin
         rx_in = 1'b0;
         repeat (3 * BIT - 8) @(posedge clk);
         #1;
         check("busy_in_break", 32'(busy), 32'd1);
         repeat (8) @(posedge clk);
         #1 rx_in = 1'b1;
      end
      repeat (32) @(posedge clk);
      #1;
      check("busy_after_frame", 32'(busy), 32'd0);
   endtask

   task automatic uld_pulse();
      @(posedge clk);
      #1 uld_rx_data = 1'b1;
      @(posedge clk);
      #1 uld_rx_data = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_data"},   32'(rx_data),   32'h00);
      check({tag, "_rx_empty"},  32'(rx_empty),  32'd1);
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      check({tag, "_overrun"},   32'(overrun),   32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   initial begin
      logic [7:0] f0;
      f0 = 8'hF0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (8) @(posedge clk);

      // Good frame, then unload.
      exp_q.push_back(tup(8'hA5, 1'b0, 1'b0, 1'b0));
      send_frame(8'hA5, 1'b1, 1'b0);
      exp_q.push_back(tup(8'hA5, 1'b1, 1'b0, 1'b0));
      uld_pulse();

      // 12-cycle glitch must be rejected in START.
      align();
      rx_in = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("busy_in_start", 32'(busy), 32'd1);
      repeat (2) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (128) @(posedge clk);
      #1;
      check("glitch_busy", 32'(busy), 32'd0);
      check("glitch_rx_empty", 32'(rx_empty), 32'd1);
      check("glitch_frame_err", 32'(frame_err), 32'd0);

      // Bad stop bit, break, then a good frame clears frame_err.
      exp_q.push_back(tup(8'hA5, 1'b1, 1'b1, 1'b0));
      send_frame(8'h3C, 1'b0, 1'b0);
      exp_q.push_back(tup(8'h11, 1'b0, 1'b0, 1'b0));
      send_frame(8'h11, 1'b1, 1'b0);
      exp_q.push_back(tup(8'h11, 1'b1, 1'b0, 1'b0));
      uld_pulse();

      // Overrun and its clearing by unload.
      exp_q.push_back(tup(8'h01, 1'b0, 1'b0, 1'b0));
      send_frame(8'h01, 1'b1, 1'b0);
      exp_q.push_back(tup(8'h02, 1'b0, 1'b0, 1'b1));
      send_frame(8'h02, 1'b1, 1'b0);
      exp_q.push_back(tup(8'h02, 1'b1, 1'b0, 1'b0));
      uld_pulse();

      // Unload coinciding with the stop-sample edge while a byte is pending.
      exp_q.push_back(tup(8'h44, 1'b0, 1'b0, 1'b0));
      send_frame(8'h44, 1'b1, 1'b0);
      exp_q.push_back(tup(8'h55, 1'b0, 1'b0, 1'b0));
      send_frame(8'h55, 1'b1, 1'b1);

      // Reset in the middle of bit 4 of 0xF0.
      align();
      rx_in = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         #1 rx_in = f0[i];
         repeat ((i == 4) ? BIT / 2 : BIT) @(posedge clk);
      end
      exp_q.push_back(tup(8'h00, 1'b1, 1'b0, 1'b0));
      #1 reset = 1'b1;
      rx_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midreset");
      reset = 1'b0;
      repeat (8) @(posedge clk);

      exp_q.push_back(tup(8'h0F, 1'b0, 1'b0, 1'b0));
      send_frame(8'h0F, 1'b1, 1'b0);

      repeat (100) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The block SHALL have parameter OS_DIV, default 16, giving clk cycles per oversample tick; bit time = 16 ticks = 16*OS_DIV clk cycles; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port uld_rx_data, input, 1 bit: consumer unload strobe.
REQ-006 The block SHALL have port rx_data, output, 8 bits: last received byte.
REQ-007 The block SHALL have port rx_empty, output, 1 bit: 1 = no unread byte held.
REQ-008 The block SHALL have port frame_err, output, 1 bit: last frame had a 0 stop bit.
REQ-009 The block SHALL have port overrun, output, 1 bit: an unread byte was overwritten.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer (both flops reset to 1) before use; all "line" references below mean the synchronized value.
REQ-012 A prescaler counting 0..OS_DIV-1 SHALL assert tick for one cycle at OS_DIV-1, wrap to 0, and run continuously.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK; a 4-bit tick counter (scnt) and a 3-bit bit index (bcnt) control sampling.
REQ-014 IDLE: on a tick with line=0 -> START, scnt=0.
REQ-015 START: on the tick where scnt reaches 7 (mid start bit): line=0 -> DATA, scnt=0, bcnt=0; line=1 -> IDLE (glitch rejected, no flags changed).
REQ-016 DATA: on the tick where scnt reaches 15, sample line into shift register bit bcnt (LSB first), scnt wraps to 0; after bcnt=7 is sampled -> STOP.
REQ-017 STOP: on the tick where scnt reaches 15: line=1 -> rx_data=shift register, rx_empty=0, frame_err=0, -> IDLE; line=0 -> frame_err=1, rx_data and rx_empty unchanged, -> BREAK.
REQ-018 BREAK: stay until a tick with line=1, then -> IDLE; no new frame is started while in BREAK.
REQ-019 Load latency: rx_data/rx_empty SHALL update on the clock edge that samples the stop bit (visible the following cycle).
REQ-020 uld_rx_data=1 SHALL set rx_empty=1 and clear overrun on the next edge; rx_data keeps its value.
REQ-021 Good-frame load while rx_empty=0 and uld_rx_data=0 SHALL overwrite rx_data and set overrun=1.
REQ-022 Good-frame load in the same cycle as uld_rx_data=1: load wins, rx_empty=0, overrun=0.
REQ-023 overrun SHALL be sticky until uld_rx_data; frame_err SHALL be sticky until the next good frame.

Reset
REQ-024 With reset=1 on an edge: state=IDLE, prescaler=0, scnt=0, bcnt=0, shift register=0, rx_data=8'h00, rx_empty=1, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes at IDLE on the next falling edge.

Verification (OS_DIV=4, bit time 64 cycles)
REQ-026 Frame 0xA5 with stop=1 -> rx_data=8'hA5, rx_empty=0, frame_err=0 about 10 bit times after the start edge; busy is high during the frame, then returns to 0.
REQ-027 Low pulse of 12 cycles on an idle line -> START aborts to IDLE; rx_empty stays 1; no flag changes.
REQ-028 Frame 0x3C with stop=0, line held low 3 bit times -> frame_err=1, rx_empty=1, busy=1 until the line returns high; a following good frame 0x11 -> rx_data=8'h11, frame_err=0.
REQ-029 Frames 0x01 then 0x02 with no uld -> rx_data=8'h02, overrun=1; uld pulse -> rx_empty=1, overrun=0.
REQ-030 uld_rx_data pulsed on the exact stop-sample cycle of 0x55 with a byte already pending -> rx_data=8'h55, rx_empty=0, overrun=0.
REQ-031 Reset pulsed during bit 4 of 0xF0 -> all outputs at reset values; next frame 0x0F received correctly.
